// File: rtl/dpram_port_arb_pkg.sv
// Requester ids, response-pipe entry layout and read latency for dpram_port_arb.
// DPRAM_ARB_RDREG_EN selects the registered read-data path (LAT = 2); otherwise LAT = 1.
package dpram_port_arb_pkg;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

`ifdef DPRAM_ARB_RDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic vld;
        logic id;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/dpram_port_arb_rsp_pipe.sv
// Response pipe: LAT-deep {vld,id} shift register that demuxes RAM read data to the issuing master.
// Latency LAT (DPRAM_ARB_RDREG_EN adds a per-master rdata register); no backpressure, one read per cycle.
module dpram_port_arb_rsp_pipe
    import dpram_port_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld_i,
    input  logic          push_id_i,
    input  logic [DW-1:0] ram_dout_i,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o
);

    logic [LAT-1:0][RSP_W-1:0] pipe_q;
    rsp_t                      head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {push_vld_i, push_id_i};
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign head        = rsp_t'(pipe_q[LAT-1]);
    assign m0_rvalid_o = head.vld && (head.id == ID_M0);
    assign m1_rvalid_o = head.vld && (head.id == ID_M1);

`ifdef DPRAM_ARB_RDREG_EN
    rsp_t          stage0;
    logic [DW-1:0] rdata0_q, rdata1_q;

    assign stage0 = rsp_t'(pipe_q[0]);

    // RAM data is valid while the entry sits in stage 0; capture it for the owner only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (stage0.vld && (stage0.id == ID_M0)) rdata0_q <= ram_dout_i;
            if (stage0.vld && (stage0.id == ID_M1)) rdata1_q <= ram_dout_i;
        end
    end

    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;
`else
    assign m0_rdata_o = m0_rvalid_o ? ram_dout_i : '0;
    assign m1_rdata_o = m1_rvalid_o ? ram_dout_i : '0;
`endif

endmodule

// File: rtl/dpram_port_arb.sv
// Shares one DPRAM port between M0/M1 with bounded-burst round-robin; grant is same-cycle, write done at that edge.
// Read data returns LAT cycles after gnt (DPRAM_ARB_RDREG_EN: LAT=2); a requester holds its request until gnt.
module dpram_port_arb
    import dpram_port_arb_pkg::*;
#(
    parameter int AW        = 11,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_wem_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_wem_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            ram_en_o,
    output logic            ram_we_o,
    output logic [DW/8-1:0] ram_wem_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic [DW-1:0]   ram_din_o,
    input  logic [DW-1:0]   ram_dout_i
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0, gnt1, any_gnt, gnt_id, sel_id;

    assign sel_id = (cnt_q < BURST_MAX) ? last_q : ~last_q;

    // Grants are forced low while reset is asserted so every output reads 0 immediately.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = (sel_id == ID_M0);
                gnt1 = (sel_id == ID_M1);
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign gnt_id   = gnt1 ? ID_M1 : ID_M0;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (!any_gnt) begin
            cnt_d = '0;
        end else if (gnt_id == last_q) begin
            if (cnt_q != BURST_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
            last_d = gnt_id;
            cnt_d  = CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID_M0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        ram_we_o   = 1'b0;
        ram_wem_o  = '0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        if (gnt0) begin
            ram_we_o   = m0_we_i;
            ram_wem_o  = m0_wem_i;
            ram_addr_o = m0_addr_i;
            ram_din_o  = m0_wdata_i;
        end else if (gnt1) begin
            ram_we_o   = m1_we_i;
            ram_wem_o  = m1_wem_i;
            ram_addr_o = m1_addr_i;
            ram_din_o  = m1_wdata_i;
        end
    end

    assign ram_en_o = any_gnt;

    dpram_port_arb_rsp_pipe #(
        .DW (DW)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .push_vld_i  (any_gnt & ~ram_we_o),
        .push_id_i   (gnt_id),
        .ram_dout_i  (ram_dout_i),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o)
    );

endmodule

// File: tb/tb_dpram_port_arb.sv
// Bench for dpram_port_arb: directed scenarios plus randomized traffic against a grant-history/RAM model.
// Build with or without DPRAM_ARB_RDREG_EN; a second instance runs MAX_BURST=1 on the same requests.
module tb_dpram_port_arb;
    import dpram_port_arb_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;
`ifdef DPRAM_ARB_RDREG_EN
    localparam bit RDREG = 1'b1;
`else
    localparam bit RDREG = 1'b0;
`endif

    logic clk, rst;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [3:0] m0_wem, m1_wem;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic ram_en, ram_we;
    logic [3:0] ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_en, b_we;
    logic [DW-1:0] b_m0_rd, b_m1_rd, b_din;
    logic [3:0] b_wem;
    logic [AW-1:0] b_addr;

    dpram_port_arb #(.AW(AW), .DW(DW), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wem_i(m0_wem), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_wem_i(m1_wem), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_wem_o(ram_wem), .ram_addr_o(ram_addr),
        .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    dpram_port_arb #(.AW(AW), .DW(DW), .MAX_BURST(1)) u_alt (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wem_i(m0_wem), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rv), .m0_rdata_o(b_m0_rd),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_wem_i(m1_wem), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rv), .m1_rdata_o(b_m1_rd),
        .ram_en_o(b_en), .ram_we_o(b_we), .ram_wem_o(b_wem), .ram_addr_o(b_addr),
        .ram_din_o(b_din), .ram_dout_i({DW{1'b0}})
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to u_dut's port: registered read, byte-masked write.
    logic [DW-1:0] ram_mem [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    typedef struct { int due; int id; logic [DW-1:0] dat; } rsp_s;
    rsp_s rq[$];
    int hist4[$], hist1[$];
    int cyc, total, bad, eg4, eg1;
    logic [1:0] erv;
    logic [DW-1:0] erd [2];
    logic [DW-1:0] held [2];

    // Grant from the spec rules applied to the grant history (-1 = idle cycle).
    function automatic int predict(input int b, input int h[$]);
        int last, streak;
        if (rst || (!m0_req && !m1_req)) return -1;
        if (m0_req != m1_req) return m0_req ? 0 : 1;
        last = 0;
        for (int i = h.size() - 1; i >= 0; i--) begin
            if (h[i] >= 0) begin
                last = h[i];
                break;
            end
        end
        streak = 0;
        for (int i = h.size() - 1; i >= 0 && h[i] == last; i--) streak++;
        return (streak < b) ? last : 1 - last;
    endfunction

    task automatic model_clear();
        hist4.delete(); hist1.delete(); rq.delete();
        held[0] = '0; held[1] = '0;
    endtask

    task automatic predict_now();
        #1;
        eg4 = predict(4, hist4);
        eg1 = predict(1, hist1);
    endtask

    task automatic advance();
        rsp_s e;
        logic gw;
        logic [3:0] gwem;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            hist4.push_back(eg4);
            hist1.push_back(eg1);
            if (eg4 >= 0) begin
                gw   = (eg4 == 0) ? m0_we : m1_we;
                gwem = (eg4 == 0) ? m0_wem : m1_wem;
                ga   = (eg4 == 0) ? m0_addr : m1_addr;
                gd   = (eg4 == 0) ? m0_wdata : m1_wdata;
                if (gw) begin
                    for (int b = 0; b < 4; b++)
                        if (gwem[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
                end else begin
                    e.due = cyc + LAT; e.id = eg4; e.dat = ref_mem[ga];
                    rq.push_back(e);
                end
            end
        end
        cyc++;
        @(negedge clk);
        erv = 2'b00;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            erv[e.id] = 1'b1;
            held[e.id] = e.dat;
        end
        for (int i = 0; i < 2; i++) erd[i] = (erv[i] || RDREG) ? held[i] : '0;
    endtask

    task automatic cyc_step();
        predict_now();
        advance();
    endtask

    task automatic set_req(input int id, input logic we, input logic [3:0] wem,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (id == 0) begin
            m0_req = 1'b1; m0_we = we; m0_wem = wem; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_wem = wem; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    task automatic drop_req(input int id);
        if (id == 0) begin
            m0_req = 1'b0; m0_we = 1'b0; m0_wem = '0; m0_addr = '0; m0_wdata = '0;
        end else begin
            m1_req = 1'b0; m1_we = 1'b0; m1_wem = '0; m1_addr = '0; m1_wdata = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_req(0); drop_req(1);
        model_clear();
        cyc_step();
        cyc_step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en, ram_we, ram_wem, ram_addr, ram_din, m0_rdata, m1_rdata} !== '0)
            begin bad++; $display("FAIL reset_outputs got gnt=%b%b en=%b addr=%h rd0=%h rd1=%h want all 0", m0_gnt, m1_gnt, ram_en, ram_addr, m0_rdata, m1_rdata); end
        total++;
        if ({b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_en, b_we, b_wem, b_addr, b_din, b_m0_rd, b_m1_rd} !== '0)
            begin bad++; $display("FAIL reset_outputs_alt got gnt=%b%b en=%b want all 0", b_m0_gnt, b_m1_gnt, b_en); end
        drop_req(0); drop_req(1);
        model_clear();
        cyc_step();
        rst = 1'b0;
        predict_now();
        total++;
        if ({m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid} !== 5'b0)
            begin bad++; $display("FAIL idle_after_reset got %b want 00000", {m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid}); end
        advance();
    endtask

    task automatic test_single_read();
        ram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        set_req(0, 1'b0, 4'h0, 11'h010, '0);
        predict_now();
        total++;
        if ({m0_gnt, m1_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 11'h010})
            begin bad++; $display("FAIL read_grant got gnt=%b%b en=%b we=%b addr=%h want 10 1 0 010", m0_gnt, m1_gnt, ram_en, ram_we, ram_addr); end
        advance();
        drop_req(0);
        for (int k = 1; k <= LAT + 1; k++) begin
            total++;
            if ({m0_rvalid, m1_rvalid} !== {(k == LAT), 1'b0})
                begin bad++; $display("FAIL read_rvalid k=%0d got %b%b want %b0", k, m0_rvalid, m1_rvalid, (k == LAT)); end
            if (k == LAT) begin
                total++;
                if (m0_rdata !== 32'hDEADBEEF)
                    begin bad++; $display("FAIL read_rdata got %h want deadbeef", m0_rdata); end
            end
            if (k == LAT + 1) begin
                total++;
                if (m0_rdata !== (RDREG ? 32'hDEADBEEF : 32'h0))
                    begin bad++; $display("FAIL rdata_after_pulse got %h want %h", m0_rdata, (RDREG ? 32'hDEADBEEF : 32'h0)); end
            end
            cyc_step();
        end
    endtask

    task automatic test_masked_write();
        set_req(1, 1'b1, 4'b0101, 11'h020, 32'hAABBCCDD);
        predict_now();
        total++;
        if ({m1_gnt, ram_en, ram_we, ram_wem, ram_addr, ram_din} !== {1'b1, 1'b1, 1'b1, 4'b0101, 11'h020, 32'hAABBCCDD})
            begin bad++; $display("FAIL write_port got gnt=%b we=%b wem=%b addr=%h din=%h", m1_gnt, ram_we, ram_wem, ram_addr, ram_din); end
        advance();
        set_req(1, 1'b0, 4'h0, 11'h020, '0);
        predict_now();
        total++;
        if ({m1_gnt, ram_we, m1_rvalid, m0_rvalid} !== 4'b1000)
            begin bad++; $display("FAIL readback_grant got %b want 1000", {m1_gnt, ram_we, m1_rvalid, m0_rvalid}); end
        advance();
        drop_req(1);
        for (int k = 1; k <= LAT; k++) begin
            total++;
            if ({m1_rvalid, m0_rvalid} !== {(k == LAT), 1'b0})
                begin bad++; $display("FAIL readback_rvalid k=%0d got %b%b", k, m1_rvalid, m0_rvalid); end
            if (k == LAT) begin
                total++;
                if (m1_rdata !== 32'h00BB00DD)
                    begin bad++; $display("FAIL masked_readback got %h want 00bb00dd", m1_rdata); end
            end
            cyc_step();
        end
    endtask

    task automatic test_burst();
        do_reset();
        set_req(0, 1'b0, 4'h0, 11'h005, '0);
        set_req(1, 1'b0, 4'h0, 11'h006, '0);
        for (int i = 0; i < 24; i++) begin
            predict_now();
            total++;
            if ({m1_gnt, m0_gnt} !== ((((i / 4) % 2) == 1) ? 2'b10 : 2'b01))
                begin bad++; $display("FAIL burst4 i=%0d got %b%b", i, m1_gnt, m0_gnt); end
            total++;
            if ({b_m1_gnt, b_m0_gnt} !== (((i % 2) == 1) ? 2'b10 : 2'b01))
                begin bad++; $display("FAIL burst1 i=%0d got %b%b", i, b_m1_gnt, b_m0_gnt); end
            advance();
            total++;
            if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== {erv, erd[1], erd[0]})
                begin bad++; $display("FAIL burst_rsp i=%0d got %b%b want %b", i, m1_rvalid, m0_rvalid, erv); end
        end
        drop_req(0); drop_req(1);
        for (int i = 0; i < LAT; i++) cyc_step();
    endtask

    task automatic test_interleaved();
        logic [DW-1:0] d [3];
        int k;
        logic [1:0] ev;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            ram_mem[i + 1] = d[i]; ref_mem[i + 1] = d[i];
        end
        for (int s = 0; s < LAT + 4; s++) begin
            drop_req(0); drop_req(1);
            if (s == 0) set_req(0, 1'b0, 4'h0, 11'd1, '0);
            if (s == 1) set_req(1, 1'b0, 4'h0, 11'd2, '0);
            if (s == 2) set_req(0, 1'b0, 4'h0, 11'd3, '0);
            predict_now();
            if (s < 3) begin
                total++;
                if ({m1_gnt, m0_gnt} !== ((s == 1) ? 2'b10 : 2'b01))
                    begin bad++; $display("FAIL inter_gnt s=%0d got %b%b", s, m1_gnt, m0_gnt); end
            end
            advance();
            k  = s + 1 - LAT;
            ev = (k == 0 || k == 2) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00;
            total++;
            if ({m1_rvalid, m0_rvalid} !== ev)
                begin bad++; $display("FAIL inter_rvalid s=%0d got %b%b want %b", s, m1_rvalid, m0_rvalid, ev); end
            if (k >= 0 && k <= 2) begin
                total++;
                if (((k == 1) ? m1_rdata : m0_rdata) !== d[k])
                    begin bad++; $display("FAIL inter_rdata s=%0d got %h want %h", s, (k == 1) ? m1_rdata : m0_rdata, d[k]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        set_req(0, 1'b0, 4'h0, 11'h010, '0);
        predict_now();
        total++;
        if (m0_gnt !== 1'b1) begin bad++; $display("FAIL midop_grant got %b want 1", m0_gnt); end
        advance();
        drop_req(0);
        rst = 1'b1;
        set_req(1, 1'b0, 4'h0, 11'h030, '0);
        model_clear();
        #1;
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en, ram_we, ram_wem, ram_addr, ram_din, m0_rdata, m1_rdata,
             b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_en, b_addr, b_m0_rd, b_m1_rd} !== '0)
            begin bad++; $display("FAIL midop_async_reset got gnt=%b%b rv=%b%b en=%b rd0=%h want all 0", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en, m0_rdata); end
        cyc_step();
        cyc_step();
        rst = 1'b0;
        drop_req(1);
        for (int i = 0; i < LAT + 3; i++) begin
            cyc_step();
            total++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00)
                begin bad++; $display("FAIL midop_dropped i=%0d got %b%b want 00", i, m0_rvalid, m1_rvalid); end
        end
        set_req(0, 1'b0, 4'h0, 11'h011, '0);
        set_req(1, 1'b0, 4'h0, 11'h012, '0);
        predict_now();
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            begin bad++; $display("FAIL midop_first_contended got %b%b want 10", m0_gnt, m1_gnt); end
        advance();
        drop_req(0); drop_req(1);
        for (int i = 0; i < LAT; i++) cyc_step();
    endtask

    task automatic new_req(input int id);
        if ($urandom_range(0, 3) == 0) drop_req(id);
        else set_req(id, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 11'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic test_random();
        logic [1+4+AW+DW:0] eram;
        do_reset();
        new_req(0); new_req(1);
        for (int n = 0; n < 400; n++) begin
            predict_now();
            eram = '0;
            if (eg4 == 0) eram = {1'b1, m0_we, m0_wem, m0_addr, m0_wdata};
            if (eg4 == 1) eram = {1'b1, m1_we, m1_wem, m1_addr, m1_wdata};
            total++;
            if ({m1_gnt, m0_gnt} !== {(eg4 == 1), (eg4 == 0)})
                begin bad++; $display("FAIL rand_gnt4 n=%0d got %b%b want id %0d", n, m1_gnt, m0_gnt, eg4); end
            total++;
            if ({b_m1_gnt, b_m0_gnt} !== {(eg1 == 1), (eg1 == 0)})
                begin bad++; $display("FAIL rand_gnt1 n=%0d got %b%b want id %0d", n, b_m1_gnt, b_m0_gnt, eg1); end
            total++;
            if ({ram_en, ram_we, ram_wem, ram_addr, ram_din} !== eram)
                begin bad++; $display("FAIL rand_ram n=%0d got %h want %h", n, {ram_en, ram_we, ram_wem, ram_addr, ram_din}, eram); end
            advance();
            total++;
            if ({m1_rvalid, m0_rvalid} !== erv)
                begin bad++; $display("FAIL rand_rvalid n=%0d got %b%b want %b", n, m1_rvalid, m0_rvalid, erv); end
            total++;
            if ({m1_rdata, m0_rdata} !== {erd[1], erd[0]})
                begin bad++; $display("FAIL rand_rdata n=%0d got %h/%h want %h/%h", n, m1_rdata, m0_rdata, erd[1], erd[0]); end
            if (eg4 == 0 || !m0_req) new_req(0);
            if (eg4 == 1 || !m1_req) new_req(1);
        end
        drop_req(0); drop_req(1);
        for (int i = 0; i < LAT; i++) cyc_step();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; eg4 = -1; eg1 = -1;
        erv = 2'b00; erd[0] = '0; erd[1] = '0;
        rst = 1'b1;
        drop_req(0); drop_req(1);
        model_clear();
        for (int a = 0; a < 2048; a++) begin
            ram_mem[a] = '0;
            ref_mem[a] = '0;
        end
        test_reset();
        test_single_read();
        test_masked_write();
        test_burst();
        test_interleaved();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
